// File: rtl/pe_ld_unit_mem_if_if.sv
// Load-unit bus bundle: decode request, memory read channel, func-unit return and debug credit.
// master = load unit, slave = decode/memory/func-unit environment.
interface pe_ld_unit_mem_if_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              ld_req_vld;
  logic [ADDR_W-1:0] ld_req_addr;
  logic              ld_req_rdy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_gnt;
  logic              mem_rd_data_vld;
  logic [DATA_W-1:0] mem_rd_data;
  logic              memory_unit_rdy;
  logic [DATA_W-1:0] ld_data;
  logic              func_unit_rdy;
  logic [CNT_W-1:0]  credit_cnt;

  modport master (
    input  ld_req_vld, ld_req_addr, mem_rd_gnt, mem_rd_data_vld, mem_rd_data, func_unit_rdy,
    output ld_req_rdy, mem_rd_en, mem_rd_addr, memory_unit_rdy, ld_data, credit_cnt
  );

  modport slave (
    output ld_req_vld, ld_req_addr, mem_rd_gnt, mem_rd_data_vld, mem_rd_data, func_unit_rdy,
    input  ld_req_rdy, mem_rd_en, mem_rd_addr, memory_unit_rdy, ld_data, credit_cnt
  );
endinterface

// File: rtl/pe_ld_unit_mem_if.sv
// PE load unit: issues loads to data memory and buffers returns in an in-order credit-limited FIFO.
// Optional macro PE_LD_UNIT_BYPASS_EN: an empty FIFO forwards returning data to ld_data in the same cycle.
//
// state | meaning
// IDLE  | may accept a load while credit_cnt < FIFO_DEPTH
// ISSUE | holding mem_rd_en/mem_rd_addr until mem_rd_gnt
module pe_ld_unit_mem_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  pe_ld_unit_mem_if_if.master bus
);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_credit;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];

  logic              w_empty;
  logic              w_full;
  logic              w_ld_req_rdy;
  logic              w_mem_rd_en;
  logic              w_accept;
  logic              w_consume;
  logic              w_fifo_wr;
  logic              w_fifo_rd;
  logic              w_mu_rdy;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_ld_data;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign w_head  = r_fifo[r_rd_ptr[IDX_W-1:0]];

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_req_rdy = 1'b0;
    w_mem_rd_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Held low during reset even though IDLE with zero credit would otherwise be ready.
        w_ld_req_rdy = i_rst_n && (r_credit < CNT_W'(FIFO_DEPTH));
        if (bus.ld_req_vld && w_ld_req_rdy) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_mem_rd_en = 1'b1;
        if (bus.mem_rd_gnt) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef PE_LD_UNIT_BYPASS_EN
  logic w_bypass;
  assign w_bypass  = w_empty && bus.mem_rd_data_vld;
  assign w_mu_rdy  = !w_empty || w_bypass;
  assign w_ld_data = !w_empty ? w_head : (w_bypass ? bus.mem_rd_data : '0);
  // A bypassed word consumed on arrival never occupies a FIFO slot.
  assign w_fifo_wr = bus.mem_rd_data_vld && !(w_bypass && bus.func_unit_rdy);
`else
  assign w_mu_rdy  = !w_empty;
  assign w_ld_data = w_empty ? '0 : w_head;
  assign w_fifo_wr = bus.mem_rd_data_vld;
`endif

  assign w_accept  = bus.ld_req_vld && w_ld_req_rdy;
  assign w_consume = bus.func_unit_rdy && w_mu_rdy;
  assign w_fifo_rd = bus.func_unit_rdy && !w_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_credit <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_addr <= bus.ld_req_addr;
      case ({w_accept, w_consume})
        2'b10:   r_credit <= r_credit + CNT_W'(1);
        2'b01:   r_credit <= r_credit - CNT_W'(1);
        default: r_credit <= r_credit;
      endcase
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: ld_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_fifo_wr) r_fifo[r_wr_ptr[IDX_W-1:0]] <= bus.mem_rd_data;
  end

  assign bus.ld_req_rdy      = w_ld_req_rdy;
  assign bus.mem_rd_en       = w_mem_rd_en;
  assign bus.mem_rd_addr     = r_addr;
  assign bus.memory_unit_rdy = w_mu_rdy;
  assign bus.ld_data         = w_ld_data;
  assign bus.credit_cnt      = r_credit;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_fifo_wr && w_full && !w_fifo_rd))
    else $error("return buffer overflow");

  a_credit_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_credit <= CNT_W'(FIFO_DEPTH))
    else $error("credit_cnt above FIFO_DEPTH");

  a_addr_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_mem_rd_en && !bus.mem_rd_gnt) |=> $stable(r_addr))
    else $error("mem_rd_addr changed while waiting for grant");

  a_pop_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(bus.func_unit_rdy && !w_mu_rdy))
    else $warning("func_unit_rdy with no head word, ignored");
endmodule
